// File: rtl/mlsu_pkg.sv
// Shared types for the matrix-load address generator.
// The struct widths depend on module parameters, so the structs are stamped out by macros wherever the widths are known.
`define MLSU_TYPEDEF_LD_REQ_T(name, AW, IW) \
  typedef struct packed { \
    logic [AW-1:0] addr; \
    logic [AW-1:0] stride; \
    logic [15:0]   rows; \
    logic [15:0]   row_bytes; \
    logic [IW-1:0] id; \
  } name;

`define MLSU_TYPEDEF_AR_T(name, AW, IW) \
  typedef struct packed { \
    logic [AW-1:0] addr; \
    logic [7:0]    len; \
    logic [2:0]    size; \
    logic [1:0]    burst; \
    logic [IW-1:0] id; \
  } name;

`define MLSU_TYPEDEF_TXN_T(name, BS) \
  typedef struct packed { \
    logic [BS-1:0] offset; \
    logic [12:0]   nbytes; \
    logic          row_last; \
    logic          last; \
  } name;

package mlsu_pkg;
  localparam int PAGE_BYTES = 4096;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} mlsu_state_e;
endpackage

// File: rtl/mlsu_load_addr_gen_if.sv
// Request, AXI AR and txn_ctrl handshakes of the load address generator.
interface mlsu_load_addr_gen_if #(
  parameter int AxiAddrWidth = 64,
  parameter int AxiIdWidth   = 4,
  parameter int BusSize      = 4
);
  `MLSU_TYPEDEF_LD_REQ_T(mlsu_ld_req_t, AxiAddrWidth, AxiIdWidth)
  `MLSU_TYPEDEF_AR_T(mlsu_ar_t, AxiAddrWidth, AxiIdWidth)
  `MLSU_TYPEDEF_TXN_T(mlsu_txn_t, BusSize)

  logic         req_valid_i;
  logic         req_ready_o;
  mlsu_ld_req_t req_i;
  logic         ar_valid_o;
  logic         ar_ready_i;
  mlsu_ar_t     ar_o;
  logic         txn_valid_o;
  logic         txn_ready_i;
  mlsu_txn_t    txn_o;

  modport master (
    input  req_valid_i, req_i, ar_ready_i, txn_ready_i,
    output req_ready_o, ar_valid_o, ar_o, txn_valid_o, txn_o
  );

  modport slave (
    output req_valid_i, req_i, ar_ready_i, txn_ready_i,
    input  req_ready_o, ar_valid_o, ar_o, txn_valid_o, txn_o
  );
endinterface

// File: rtl/mlsu_burst_calc.sv
// Sizes the next burst: bounded by the bytes left in the row, the 4 KiB page and the max burst length.
module mlsu_burst_calc
  import mlsu_pkg::*;
#(
  parameter int BusBytes      = 16,
  parameter int MaxBurstBeats = 256,
  localparam int BusSize      = $clog2(BusBytes)
) (
  input  logic [11:0]        cur_addr,   // page-offset bits of the current address
  input  logic [15:0]        row_left,
  output logic [BusSize-1:0] offset,
  output logic [12:0]        nbytes,
  output logic [7:0]         len
);
  localparam int MaxBytes = MaxBurstBeats * BusBytes;

  logic [12:0] to4k, lenmax, cap;
  logic [13:0] tot;

  always_comb begin
    offset = cur_addr[BusSize-1:0];
    to4k   = 13'(PAGE_BYTES) - {1'b0, cur_addr};
    lenmax = 13'(MaxBytes) - {{(13-BusSize){1'b0}}, offset};
    cap    = (to4k < lenmax) ? to4k : lenmax;
    nbytes = (row_left < {3'b000, cap}) ? row_left[12:0] : cap;
    // beats covered from the aligned start of the first beat to the last byte
    tot    = {1'b0, nbytes} + 14'(offset) + 14'(BusBytes - 1);
    len    = 8'((tot >> BusSize) - 14'd1);
  end
endmodule

// File: rtl/mlsu_load_addr_gen.sv
// Matrix-load address generator: splits one strided 2-D load into AXI INCR bursts,
// emitting an AR and a matching txn_ctrl entry per burst through a forked handshake.
module mlsu_load_addr_gen
  import mlsu_pkg::*;
#(
  parameter int AxiDataWidth  = 128,
  parameter int AxiAddrWidth  = 64,
  parameter int AxiIdWidth    = 4,
  parameter int MaxBurstBeats = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  mlsu_load_addr_gen_if.master bus,
  output logic                busy_o,
  output logic                done_o
);
  localparam int BusBytes = AxiDataWidth / 8;
  localparam int BusSize  = $clog2(BusBytes);

  if (MaxBurstBeats < 1 || MaxBurstBeats > 256 || (MaxBurstBeats & (MaxBurstBeats - 1)) != 0 ||
      MaxBurstBeats * BusBytes > PAGE_BYTES) begin : g_param_err
    $error("mlsu_load_addr_gen: illegal MaxBurstBeats for this bus width");
  end

  mlsu_state_e state_q, state_d;

  logic [AxiAddrWidth-1:0] cur_addr_q, row_base_q, stride_q;
  logic [15:0]             row_left_q, rows_left_q, row_bytes_q;
  logic [AxiIdWidth-1:0]   id_q;
  logic                    ar_sent_q, txn_sent_q;

  logic [BusSize-1:0] offset;
  logic [12:0]        nbytes;
  logic [7:0]         len;
  logic               row_last, last, issuing;
  logic               req_fire, ar_fire, txn_fire, burst_done;

  mlsu_burst_calc #(
    .BusBytes      (BusBytes),
    .MaxBurstBeats (MaxBurstBeats)
  ) u_calc (
    .cur_addr (cur_addr_q[11:0]),
    .row_left (row_left_q),
    .offset   (offset),
    .nbytes   (nbytes),
    .len      (len)
  );

  assign row_last = ({3'b000, nbytes} == row_left_q);
  assign last     = row_last && (rows_left_q == 16'd1);
  assign issuing  = (state_q == ISSUE);

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.ar_valid_o  = issuing && !ar_sent_q;
  assign bus.txn_valid_o = issuing && !txn_sent_q;

  assign req_fire   = bus.req_valid_i && bus.req_ready_o;
  assign ar_fire    = bus.ar_valid_o && bus.ar_ready_i;
  assign txn_fire   = bus.txn_valid_o && bus.txn_ready_i;
  // a burst retires once each channel has fired, in either order
  assign burst_done = issuing && (ar_sent_q || ar_fire) && (txn_sent_q || txn_fire);

  assign bus.ar_o.addr  = cur_addr_q;
  assign bus.ar_o.len   = len;
  assign bus.ar_o.size  = 3'(BusSize);
  assign bus.ar_o.burst = AXI_BURST_INCR;
  assign bus.ar_o.id    = id_q;

  assign bus.txn_o.offset   = offset;
  assign bus.txn_o.nbytes   = nbytes;
  assign bus.txn_o.row_last = row_last;
  assign bus.txn_o.last     = last;

  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    case (state_q)
      IDLE: if (req_fire)
              state_d = (bus.req_i.rows != 16'd0 && bus.req_i.row_bytes != 16'd0) ? ISSUE : DONE;
      ISSUE: if (burst_done && last) state_d = DONE;
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cur_addr_q  <= '0;
      row_base_q  <= '0;
      stride_q    <= '0;
      row_left_q  <= '0;
      rows_left_q <= '0;
      row_bytes_q <= '0;
      id_q        <= '0;
      ar_sent_q   <= 1'b0;
      txn_sent_q  <= 1'b0;
    end else begin
      if (req_fire) begin
        cur_addr_q  <= bus.req_i.addr;
        row_base_q  <= bus.req_i.addr;
        stride_q    <= bus.req_i.stride;
        row_left_q  <= bus.req_i.row_bytes;
        rows_left_q <= bus.req_i.rows;
        row_bytes_q <= bus.req_i.row_bytes;
        id_q        <= bus.req_i.id;
      end
      if (burst_done) begin
        ar_sent_q  <= 1'b0;
        txn_sent_q <= 1'b0;
        if (row_last) begin
          row_base_q  <= row_base_q + stride_q;
          cur_addr_q  <= row_base_q + stride_q;
          row_left_q  <= row_bytes_q;
          rows_left_q <= rows_left_q - 16'd1;
        end else begin
          cur_addr_q <= cur_addr_q + AxiAddrWidth'(nbytes);
          row_left_q <= row_left_q - {3'b000, nbytes};
        end
      end else begin
        if (ar_fire)  ar_sent_q  <= 1'b1;
        if (txn_fire) txn_sent_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mlsu_load_addr_gen.sv
// Bench for mlsu_load_addr_gen: directed corner cases plus random requests against a burst-list model.
module tb_mlsu_load_addr_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mlsu_load_addr_gen_if #(.AxiAddrWidth(64), .AxiIdWidth(4), .BusSize(4)) bus ();
  logic busy, done;

  mlsu_load_addr_gen #(
    .AxiDataWidth(128), .AxiAddrWidth(64), .AxiIdWidth(4), .MaxBurstBeats(256)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .busy_o(busy), .done_o(done)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [3:0]  off;
    logic [12:0] nb;
    logic        rl;
    logic        last;
  } exp_t;

  exp_t exp_ar[$];
  exp_t exp_txn[$];
  int total = 0;
  int bad = 0;
  int n_ar, n_txn;
  logic [3:0]  cur_id;
  logic        ar_wait = 1'b0, txn_wait = 1'b0;
  logic [63:0] ar_hold;
  logic [12:0] txn_hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected burst list from the request: walk each row, cutting at page and max-burst limits.
  task automatic build(input logic [63:0] a0, input logic [63:0] stride, input int rows, input int rb);
    logic [63:0] base, a;
    int rem, page, lim, n, off;
    exp_t e;
    exp_ar.delete();
    exp_txn.delete();
    base = a0;
    for (int r = 0; r < rows; r++) begin
      a = base;
      rem = rb;
      while (rem > 0) begin
        off  = int'(a[3:0]);
        page = 4096 - int'(a[11:0]);
        lim  = 256 * 16 - off;
        n = rem;
        if (page < n) n = page;
        if (lim < n) n = lim;
        e.addr = a;
        e.off  = a[3:0];
        e.nb   = 13'(n);
        e.len  = 8'((off + n + 15) / 16 - 1);
        e.rl   = (n == rem);
        e.last = (n == rem) && (r == rows - 1);
        exp_ar.push_back(e);
        exp_txn.push_back(e);
        a = a + 64'(n);
        rem = rem - n;
      end
      base = base + stride;
    end
  endtask

  // One clock: observe fires and payload stability at the negedge, return just after the posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (ar_wait) begin
      chk("ar_valid_held", bus.ar_valid_o, 1);
      chk("ar_addr_stable", bus.ar_o.addr, ar_hold);
    end
    if (txn_wait) begin
      chk("txn_valid_held", bus.txn_valid_o, 1);
      chk("txn_nbytes_stable", bus.txn_o.nbytes, txn_hold);
    end
    ar_wait  = bus.ar_valid_o && !bus.ar_ready_i;
    txn_wait = bus.txn_valid_o && !bus.txn_ready_i;
    ar_hold  = bus.ar_o.addr;
    txn_hold = bus.txn_o.nbytes;
    if (bus.ar_valid_o && bus.ar_ready_i) begin
      n_ar++;
      if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
      else begin
        e = exp_ar.pop_front();
        chk("ar_addr", bus.ar_o.addr, e.addr);
        chk("ar_len", bus.ar_o.len, e.len);
        chk("ar_size", bus.ar_o.size, 4);
        chk("ar_burst", bus.ar_o.burst, 1);
        chk("ar_id", bus.ar_o.id, cur_id);
      end
    end
    if (bus.txn_valid_o && bus.txn_ready_i) begin
      n_txn++;
      if (exp_txn.size() == 0) chk("txn_unexpected", 1, 0);
      else begin
        e = exp_txn.pop_front();
        chk("txn_offset", bus.txn_o.offset, e.off);
        chk("txn_nbytes", bus.txn_o.nbytes, e.nb);
        chk("txn_row_last", bus.txn_o.row_last, e.rl);
        chk("txn_last", bus.txn_o.last, e.last);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: readies held high, 1: random readies, 2: AR stalled for 5 cycles
  task automatic run_req(input logic [63:0] a0, input logic [63:0] stride, input int rows,
                         input int rb, input int mode);
    int nb, k;
    build(a0, stride, rows, rb);
    nb = exp_ar.size();
    n_ar = 0;
    n_txn = 0;
    cur_id = 4'($urandom);
    chk("req_ready_idle", bus.req_ready_o, 1);
    bus.req_i.addr      = a0;
    bus.req_i.stride    = stride;
    bus.req_i.rows      = 16'(rows);
    bus.req_i.row_bytes = 16'(rb);
    bus.req_i.id        = cur_id;
    bus.req_valid_i     = 1'b1;
    bus.ar_ready_i      = 1'b1;
    bus.txn_ready_i     = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("req_ready_busy", bus.req_ready_o, 0);
    if (nb == 0) begin
      chk("empty_no_ar", bus.ar_valid_o, 0);
      chk("empty_done", done, 1);
    end else begin
      chk("first_ar_valid", bus.ar_valid_o, 1);
      chk("first_txn_valid", bus.txn_valid_o, 1);
    end
    k = 0;
    while (!done && k < 2000) begin
      if (mode == 2 && k == 5) begin
        chk("stall_txn_fires", n_txn, 1);
        chk("stall_ar_fires", n_ar, 0);
        chk("stall_txn_valid", bus.txn_valid_o, 0);
        chk("stall_ar_valid", bus.ar_valid_o, 1);
      end
      case (mode)
        0: begin bus.ar_ready_i = 1'b1; bus.txn_ready_i = 1'b1; end
        1: begin
          bus.ar_ready_i  = ($urandom_range(0, 3) != 0);
          bus.txn_ready_i = ($urandom_range(0, 3) != 0);
        end
        default: begin bus.ar_ready_i = (k >= 5); bus.txn_ready_i = 1'b1; end
      endcase
      step();
      k++;
    end
    if (!done) chk("done_timeout", 0, 1);
    if (mode == 0 && nb != 0) chk("cycles_to_done", k, nb);
    chk("ar_count", n_ar, nb);
    chk("txn_count", n_txn, nb);
    chk("ar_left", exp_ar.size(), 0);
    chk("txn_left", exp_txn.size(), 0);
    step();
    chk("done_pulse_width", done, 0);
    chk("ready_after_done", bus.req_ready_o, 1);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    logic [63:0] ra, rs;
    logic [31:0] r32;
    int rrows, rrb;
    bus.req_valid_i = 1'b0;
    bus.req_i       = '0;
    bus.ar_ready_i  = 1'b0;
    bus.txn_ready_i = 1'b0;
    step();
    step();
    chk("rst_req_ready", bus.req_ready_o, 1);
    chk("rst_ar_valid", bus.ar_valid_o, 0);
    chk("rst_txn_valid", bus.txn_valid_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    step();

    run_req(64'h1000, 64'h0, 1, 64, 0);
    run_req(64'h0FF8, 64'h0, 1, 32, 0);
    run_req(64'h2000, 64'h100, 3, 16, 0);
    run_req(64'h0, 64'h0, 1, 8192, 0);
    run_req(64'h100, 64'hFFFF_FFFF_FFFF_FF00, 2, 16, 0);
    run_req(64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 2, 16, 0);
    run_req(64'h0FF8, 64'h0, 1, 32, 2);
    run_req(64'h3000, 64'h0, 0, 64, 0);
    run_req(64'h3000, 64'h40, 2, 0, 0);

    // reset while a burst is stalled
    build(64'h0, 64'h0, 1, 8192);
    cur_id = 4'h5;
    bus.req_i.addr = 64'h0; bus.req_i.stride = 64'h0; bus.req_i.rows = 16'd1;
    bus.req_i.row_bytes = 16'd8192; bus.req_i.id = cur_id;
    bus.req_valid_i = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
    bus.ar_ready_i  = 1'b0;
    bus.txn_ready_i = 1'b0;
    step();
    step();
    chk("pre_rst_ar_valid", bus.ar_valid_o, 1);
    rst_n = 1'b0;
    step();
    ar_wait = 1'b0;
    txn_wait = 1'b0;
    chk("midrst_ar_valid", bus.ar_valid_o, 0);
    chk("midrst_txn_valid", bus.txn_valid_o, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", bus.req_ready_o, 1);
    chk("midrst_done", done, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) ra[11:0] = 12'(4095 - $urandom_range(0, 40));
      r32 = $urandom;
      rs = {{32{r32[31]}}, r32};
      rrows = $urandom_range(0, 4);
      rrb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9000) : $urandom_range(0, 100);
      run_req(ra, rs, rrows, rrb, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
